// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one muxed write port,
// optional zero register, optional write-to-read bypass and a pending-load scoreboard.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic              regdst,
  input  logic              regwrite,
  input  logic              memtoreg,
  input  logic [DATA_W-1:0] alu_ou_result,
  input  logic [DATA_W-1:0] mdr_result,
  input  logic              resv_en,
  input  logic [ADDR_W-1:0] resv_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rs_pending,
  output logic              rt_pending,
  output logic [ADDR_W:0]   pending_cnt
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_pend;
  logic [ADDR_W:0]   r_cnt;

  logic [ADDR_W-1:0] w_wa;
  logic [DATA_W-1:0] w_wd;
  logic              w_we;
  logic              w_rsv;
  logic [DEPTH-1:0]  w_pend_nxt;
  logic [ADDR_W:0]   w_cnt_nxt;

  // An index that names real, writable storage (also the only indices that read non-zero).
  function automatic logic f_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_L) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign w_wa  = regdst ? rd : rt;
  assign w_wd  = memtoreg ? mdr_result : alu_ou_result;
  assign w_we  = regwrite && f_ok(w_wa);
  assign w_rsv = resv_en && f_ok(resv_addr);

  // A reservation beats a same-cycle write: the write lands but a newer load is outstanding.
  always_comb begin
    w_pend_nxt = r_pend;
    w_cnt_nxt  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_rsv && (resv_addr == ADDR_W'(i))) begin
        w_pend_nxt[i] = 1'b1;
      end else if (w_we && (w_wa == ADDR_W'(i))) begin
        w_pend_nxt[i] = 1'b0;
      end
      w_cnt_nxt = w_cnt_nxt + (ADDR_W+1)'(w_pend_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_we) begin
        r_regs[w_wa] <= w_wd;
      end
      r_pend <= w_pend_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  // Pending flags come straight from the stored bits, so a clearing write drops them a cycle later.
  always_comb begin
    rs_data    = '0;
    rt_data    = '0;
    rs_pending = 1'b0;
    rt_pending = 1'b0;
    if (rst) begin
      if (f_ok(rs)) begin
        rs_data    = ((BYPASS != 0) && w_we && (w_wa == rs)) ? w_wd : r_regs[rs];
        rs_pending = r_pend[rs];
      end
      if (f_ok(rt)) begin
        rt_data    = ((BYPASS != 0) && w_we && (w_wa == rt)) ? w_wd : r_regs[rt];
        rt_pending = r_pend[rt];
      end
    end
  end

  assign pending_cnt = r_cnt;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: default build, a BYPASS=0 build and a
// DEPTH=20 / ZERO_REG=0 build all share one set of inputs.
module tb_reg_file_sb;

  logic        clk;
  logic        rst;
  logic [4:0]  rs, rt, rd, resv_addr;
  logic        regdst, regwrite, memtoreg, resv_en;
  logic [31:0] alu, mdr;

  logic [31:0] a_rs, a_rt, b_rs, b_rt, s_rs, s_rt;
  logic        a_rsp, a_rtp, b_rsp, b_rtp, s_rsp, s_rtp;
  logic [5:0]  a_cnt, b_cnt, s_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        rst;
    logic [4:0]  rs, rt, rd;
    logic        regdst, regwrite, memtoreg;
    logic [31:0] alu, mdr;
    logic        resv_en;
    logic [4:0]  resv_addr;
    logic [31:0] e_rs, e_rt, e_rs_nb, e_rt_nb;
    logic        e_rsp, e_rtp;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  reg_file_sb u_dut (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd), .regdst(regdst),
    .regwrite(regwrite), .memtoreg(memtoreg), .alu_ou_result(alu),
    .mdr_result(mdr), .resv_en(resv_en), .resv_addr(resv_addr),
    .rs_data(a_rs), .rt_data(a_rt), .rs_pending(a_rsp), .rt_pending(a_rtp),
    .pending_cnt(a_cnt)
  );

  reg_file_sb #(.BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd), .regdst(regdst),
    .regwrite(regwrite), .memtoreg(memtoreg), .alu_ou_result(alu),
    .mdr_result(mdr), .resv_en(resv_en), .resv_addr(resv_addr),
    .rs_data(b_rs), .rt_data(b_rt), .rs_pending(b_rsp), .rt_pending(b_rtp),
    .pending_cnt(b_cnt)
  );

  reg_file_sb #(.DEPTH(20), .ZERO_REG(0)) u_small (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd), .regdst(regdst),
    .regwrite(regwrite), .memtoreg(memtoreg), .alu_ou_result(alu),
    .mdr_result(mdr), .resv_en(resv_en), .resv_addr(resv_addr),
    .rs_data(s_rs), .rt_data(s_rt), .rs_pending(s_rsp), .rt_pending(s_rtp),
    .pending_cnt(s_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: rst, rs, rt, rd, regdst, regwrite, memtoreg, alu, mdr, resv_en, resv_addr,
  // expected rs/rt data (bypass build), expected rs/rt data (no-bypass build), rs_pend, rt_pend, cnt.
  function automatic vec_t v(input int r, input int a_s, input int a_t, input int a_d,
                             input int dst, input int we, input int m2r,
                             input logic [31:0] a, input logic [31:0] m,
                             input int rv, input int ra,
                             input logic [31:0] ers, input logic [31:0] ert,
                             input logic [31:0] ersn, input logic [31:0] ertn,
                             input int ersp, input int ertp, input int ec);
    vec_t x;
    x.rst = r[0]; x.rs = 5'(a_s); x.rt = 5'(a_t); x.rd = 5'(a_d);
    x.regdst = dst[0]; x.regwrite = we[0]; x.memtoreg = m2r[0];
    x.alu = a; x.mdr = m; x.resv_en = rv[0]; x.resv_addr = 5'(ra);
    x.e_rs = ers; x.e_rt = ert; x.e_rs_nb = ersn; x.e_rt_nb = ertn;
    x.e_rsp = ersp[0]; x.e_rtp = ertp[0]; x.e_cnt = 6'(ec);
    return x;
  endfunction

  // Driver
  task automatic apply(input vec_t x);
    rst = x.rst; rs = x.rs; rt = x.rt; rd = x.rd;
    regdst = x.regdst; regwrite = x.regwrite; memtoreg = x.memtoreg;
    alu = x.alu; mdr = x.mdr; resv_en = x.resv_en; resv_addr = x.resv_addr;
  endtask

  // Scoreboard compare
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    apply(v(0, 0,0, 0,0,0,0, 0,0, 0,0, 0,0,0,0, 0,0,0));
    repeat (2) @(posedge clk);

    // reset still held: write and reservation must be ignored, outputs forced to 0
    vecs.push_back(v(0, 3,7, 5,1,1,0, 32'hDEAD,0,          1,5, 0,0,0,0, 0,0,0));
    vecs.push_back(v(1, 5,7, 0,0,0,0, 0,0,                 0,0, 0,0,0,0, 0,0,0));
    // write via rd from ALU, then via rt from MDR
    vecs.push_back(v(1, 5,6, 5,1,1,0, 32'h1234,32'h9999,   0,0, 32'h1234,0,0,0, 0,0,0));
    vecs.push_back(v(1, 5,6, 5,0,1,1, 32'h7777,32'hBEEF,   0,0, 32'h1234,32'hBEEF,32'h1234,0, 0,0,0));
    vecs.push_back(v(1, 6,5, 0,0,0,0, 0,0,                 0,0, 32'hBEEF,32'h1234,32'hBEEF,32'h1234, 0,0,0));
    // zero register: write and reservation both dropped
    vecs.push_back(v(1, 0,0, 0,1,1,0, 32'hFFFF_FFFF,0,     1,0, 0,0,0,0, 0,0,0));
    vecs.push_back(v(1, 0,5, 0,0,0,0, 0,0,                 0,0, 0,32'h1234,0,32'h1234, 0,0,0));
    // bypass vs. no bypass
    vecs.push_back(v(1, 9,9, 9,1,1,0, 32'hA5A5,0,          0,0, 32'hA5A5,32'hA5A5,0,0, 0,0,0));
    vecs.push_back(v(1, 9,6, 0,0,0,0, 0,0,                 0,0, 32'hA5A5,32'hBEEF,32'hA5A5,32'hBEEF, 0,0,0));
    // scoreboard: reserve, observe, clear by MDR write
    vecs.push_back(v(1, 4,9, 0,0,0,0, 0,0,                 1,4, 0,32'hA5A5,0,32'hA5A5, 0,0,0));
    vecs.push_back(v(1, 4,4, 0,0,0,0, 0,0,                 0,0, 0,0,0,0, 1,1,1));
    vecs.push_back(v(1, 4,4, 0,0,1,1, 0,32'h4444,          0,0, 32'h4444,32'h4444,0,0, 1,1,1));
    vecs.push_back(v(1, 4,9, 0,0,0,0, 0,0,                 0,0, 32'h4444,32'hA5A5,32'h4444,32'hA5A5, 0,0,0));
    // simultaneous reserve + write: data lands, pending stays set
    vecs.push_back(v(1, 4,4, 4,1,1,0, 32'h5555,0,          1,4, 32'h5555,32'h5555,32'h4444,32'h4444, 0,0,0));
    vecs.push_back(v(1, 4,5, 0,0,0,0, 0,0,                 0,0, 32'h5555,32'h1234,32'h5555,32'h1234, 1,0,1));
    // reset mid-load
    vecs.push_back(v(1, 2,3, 0,0,0,0, 0,0,                 1,2, 0,0,0,0, 0,0,1));
    vecs.push_back(v(1, 2,4, 0,0,0,0, 0,0,                 1,3, 0,32'h5555,0,32'h5555, 1,1,2));
    vecs.push_back(v(1, 3,2, 0,0,0,0, 0,0,                 0,0, 0,0,0,0, 1,1,3));
    vecs.push_back(v(0, 4,5, 2,1,1,0, 32'h2222,0,          1,7, 0,0,0,0, 0,0,3));
    vecs.push_back(v(1, 4,2, 2,1,1,0, 32'h2222,0,          0,0, 0,32'h2222,0,0, 0,0,0));
    vecs.push_back(v(1, 2,6, 0,0,0,0, 0,0,                 0,0, 32'h2222,0,32'h2222,0, 0,0,0));

    foreach (vecs[i]) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      chk($sformatf("v%0d rs_data", i),    a_rs, vecs[i].e_rs);
      chk($sformatf("v%0d rt_data", i),    a_rt, vecs[i].e_rt);
      chk($sformatf("v%0d rs_pend", i),    32'(a_rsp), 32'(vecs[i].e_rsp));
      chk($sformatf("v%0d rt_pend", i),    32'(a_rtp), 32'(vecs[i].e_rtp));
      chk($sformatf("v%0d cnt", i),        32'(a_cnt), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d nb rs_data", i), b_rs, vecs[i].e_rs_nb);
      chk($sformatf("v%0d nb rt_data", i), b_rt, vecs[i].e_rt_nb);
      chk($sformatf("v%0d nb cnt", i),     32'(b_cnt), 32'(vecs[i].e_cnt));
    end

    // DEPTH=20, ZERO_REG=0: reg0 is ordinary, indices 20..31 are absent
    @(negedge clk);
    apply(v(0, 0,0, 0,0,0,0, 0,0, 0,0, 0,0,0,0, 0,0,0));
    @(negedge clk);
    apply(v(1, 0,0, 0,1,1,0, 32'h0F0F,0, 1,25, 0,0,0,0, 0,0,0));
    #1;
    chk("small reg0 bypass", s_rs, 32'h0F0F);
    chk("small cnt after reset", 32'(s_cnt), 32'd0);
    @(negedge clk);
    apply(v(1, 25,0, 25,1,1,0, 32'hAAAA,0, 1,0, 0,0,0,0, 0,0,0));
    #1;
    chk("small out-of-range read", s_rs, 32'd0);
    chk("small reg0 readback", s_rt, 32'h0F0F);
    chk("small out-of-range pend", 32'(s_rsp), 32'd0);
    chk("small bad resv ignored", 32'(s_cnt), 32'd0);
    @(negedge clk);
    apply(v(1, 0,25, 0,0,0,0, 0,0, 1,19, 0,0,0,0, 0,0,0));
    #1;
    chk("small reg0 pend", 32'(s_rsp), 32'd1);
    chk("small oor rt pend", 32'(s_rtp), 32'd0);
    chk("small cnt one", 32'(s_cnt), 32'd1);
    chk("small reg0 data", s_rs, 32'h0F0F);
    chk("small oor rt data", s_rt, 32'd0);
    @(negedge clk);
    apply(v(1, 19,0, 0,0,0,0, 0,0, 0,0, 0,0,0,0, 0,0,0));
    #1;
    chk("small reg19 pend", 32'(s_rsp), 32'd1);
    chk("small cnt two", 32'(s_cnt), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the datapath register file.
- Two combinational read ports and one write port, with the write-destination mux (rd/rt) and write-data mux (ALU/MDR) folded in.
- Optional hardwired zero register, optional write-to-read bypass, and a per-register pending scoreboard so the controller can stall on multi-cycle loads.
- Sits between decode (read addresses, reservation) and writeback (ALU/MDR results).

Parameters:
DATA_W, 32, register data width in bits
ADDR_W, 5, register address width
DEPTH, 32, number of implemented registers (1..2^ADDR_W)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never pending
BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  reset, synchronous, active-low
rs  in  ADDR_W  read address A
rt  in  ADDR_W  read address B; also the write destination when regdst=0
rd  in  ADDR_W  write destination when regdst=1
regdst  in  1  write-address select: 1 = rd, 0 = rt
regwrite  in  1  write enable
memtoreg  in  1  write-data select: 1 = mdr_result, 0 = alu_ou_result
alu_ou_result  in  DATA_W  ALU writeback data
mdr_result  in  DATA_W  memory writeback data
resv_en  in  1  mark resv_addr pending (load issued)
resv_addr  in  ADDR_W  register to reserve
rs_data  out  DATA_W  read data A
rt_data  out  DATA_W  read data B
rs_pending  out  1  rs has an outstanding reservation
rt_pending  out  1  rt has an outstanding reservation
pending_cnt  out  ADDR_W+1  number of pending registers

Behaviour:
- Write address: wa = regdst ? rd : rt. Write data: wd = memtoreg ? mdr_result : alu_ou_result.
- Write effect: wa is a writable index (< DEPTH, and not 0 when ZERO_REG=1) and regwrite=1 -> reg[wa] <= wd at the rising edge. Non-writable wa -> write silently dropped.
- Reads are combinational:
  - rs_data = 0 if rs >= DEPTH, or ZERO_REG=1 and rs=0.
  - Otherwise, if BYPASS=1, regwrite=1 and wa==rs with wa writable -> wd.
  - Otherwise reg[rs]. rt_data is identical using rt.
- BYPASS=0: the read returns the old value in the write cycle and the new value from the next cycle.
- Scoreboard: one pending bit per register.
  - resv_en=1 with a writable resv_addr sets bit[resv_addr] at the edge.
  - A write to wa clears bit[wa] at the edge.
  - Same register reserved and written in the same cycle: the reservation wins, bit stays 1 (the write lands, a newer load is outstanding).
  - Reservation of a non-writable address: ignored.
- rs_pending = bit[rs] for a valid rs, else 0. rt_pending likewise.
  - A same-cycle clearing write does NOT drop pending combinationally; it drops the cycle after.
- pending_cnt is the registered population count of the pending bits, updated every edge. Maximum value DEPTH (DEPTH-1 when ZERO_REG=1).
- Reset: rst=0 sampled at an edge clears every register to 0 and every pending bit to 0; pending_cnt = 0 the next cycle.
  - While rst=0: rs_data, rt_data, rs_pending and rt_pending are forced to 0 combinationally.
  - Writes and reservations during reset are ignored.
  - Reset asserted between a reservation and its write (mid-load) discards the reservation; the late write after reset is accepted as a normal write.
- No initial-block values. The register contents after reset are all zero.

Test Plan:
- Reset then read: rst=0 for 2 cycles, release; rs=3, rt=7 -> rs_data=0, rt_data=0, pending_cnt=0.
- Mux/write: regwrite=1, regdst=1, rd=5, memtoreg=0, alu=32'h1234 -> next cycle rs=5 reads 32'h1234. Then regdst=0, rt=6, memtoreg=1, mdr=32'hBEEF -> reg6 = 32'hBEEF.
- Zero register: write 32'hFFFF_FFFF to reg0 -> rs=0 reads 0. resv_addr=0 -> rs_pending=0, pending_cnt unchanged.
- Bypass: same cycle write reg9=32'hA5A5 and rs=9.
  - BYPASS=1 -> rs_data=32'hA5A5 in that cycle.
  - BYPASS=0 -> old value in that cycle, 32'hA5A5 the next cycle.
- Scoreboard: resv reg4 -> next cycle rs=4 gives rs_pending=1, pending_cnt=1. Write reg4 from MDR -> pending clears the following cycle, cnt=0. Simultaneous resv+write reg4 -> pending stays 1, data updated.
- Reset mid-load: reserve reg2, 3, 4 (cnt=3); assert rst=0 for one edge -> all pending 0, cnt=0, all regs 0.
